uart_rx_deframer: RTL and testbench

UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

---
 rtl/uart_rx_deframer.sv | 155 +++++++++++++++
 tb/tb_uart_rx_deframer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - UART receive deframer: samples data and stop bits after a start-bit-found pulse
//
// Purpose:
//   An upstream start detector pulses i_found at the middle of a start bit.
//   This block then counts OSR enabled ticks per bit. It samples each data bit
//   at mid-bit, LSB first, and checks the stop bit. A good frame updates o_data
//   and pulses o_valid. A frame whose stop bit reads 0 pulses o_frame_err and
//   leaves o_data untouched.
//
// Parameters:
//   OSR        oversample ratio (enabled i_clk cycles per bit), even, >= 4
//   DATA_BITS  data bits per frame, 5..9
//
// Ports:
//   i_clk        oversample clock (OSR x baud)
//   i_rst_n      asynchronous active-low reset
//   i_en         tick enable; nothing advances on cycles with i_en=0
//   i_rx         synchronised RX line
//   i_found      start-bit-found pulse, only honoured in IDLE with i_en=1
//   o_data       last good received word
//   o_valid      one-cycle pulse when o_data is updated
//   o_frame_err  one-cycle pulse when the stop bit is sampled as 0
//   o_busy       high while a frame is in progress (DATA or STOP)

module uart_rx_deframer #(
  parameter int OSR       = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_rx,
  input  logic                 i_found,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_MAX = TW'(OSR - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          tick_q,  tick_d;
  logic [BW-1:0]          bit_q,   bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q,  data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q,  ferr_d;

  // The tick counter restarts at 0 on the i_found edge. So it reads OSR-1
  // exactly on every OSR-th enabled cycle afterwards. That cycle is the middle
  // of the next bit, because i_found itself arrives at mid-start-bit.
  logic tick_wrap;
  assign tick_wrap = (tick_q == TICK_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    // The pulses default low, so they last a single cycle even when i_en=0.
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_en && i_found) begin
          state_d = DATA;
          tick_d  = '0;
          bit_d   = '0;
          shift_d = '0;
        end
      end

      DATA: begin
        if (i_en) begin
          if (tick_wrap) begin
            tick_d  = '0;
            // Shifting in from the MSB side leaves the first (LSB) bit at [0]
            // once all DATA_BITS samples are in.
            shift_d = {i_rx, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_MAX) begin
              bit_d   = '0;
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (i_en) begin
          if (tick_wrap) begin
            tick_d  = '0;
            // Return to IDLE on the stop-sample edge. This lets a back-to-back
            // i_found on the very next cycle start the next frame.
            state_d = IDLE;
            if (i_rx) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;

  localparam int OSR       = 16;
  localparam int DATA_BITS = 8;
  localparam int TOTAL     = (DATA_BITS + 1) * OSR;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic                 rx;
  logic                 found;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ferr;
  logic                 busy;

  uart_rx_deframer #(.OSR(OSR), .DATA_BITS(DATA_BITS)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_rx       (rx),
    .i_found    (found),
    .o_data     (data),
    .o_valid    (valid),
    .o_frame_err(ferr),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic                 err;
    int                   at_cyc;
  } exp_t;

  exp_t                 sb[$];
  logic [DATA_BITS-1:0] model_data = '0;

  // Scoreboard side: every pulse must match the next expected frame outcome.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid || ferr) begin
        check("pulse_exclusive", {31'd0, valid & ferr}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", {30'd0, valid, ferr}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_kind_err", {31'd0, ferr}, {31'd0, e.err});
          check("pulse_cycle", cyc, e.at_cyc);
          if (!e.err) begin
            check("valid_data", {24'd0, data}, {24'd0, e.data});
            model_data = e.data;
          end
        end
      end
      check("data_hold", {24'd0, data}, {24'd0, model_data});
    end
  end

  // Line level seen k enabled cycles after the i_found edge. Bit n is centred
  // on k=(n+1)*OSR; the optional glitch sits on bit boundaries, far from it.
  function automatic logic line_bit(input logic [DATA_BITS-1:0] d, input logic stop,
                                    input int k, input logic glitch);
    int   seg;
    logic b;
    seg = (k + OSR / 2) / OSR;
    if (seg == 0)              b = 1'b0;
    else if (seg <= DATA_BITS) b = d[seg-1];
    else                       b = stop;
    if (glitch && (k % OSR) == OSR / 2) b = ~b;
    return b;
  endfunction

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic                 stop;
    int                   gap_at;
    int                   gap_len;
    logic                 extra_found;
    logic                 glitch;
    logic                 exp_err;
    int                   exp_lat;
  } vec_t;

  task automatic send(input logic [DATA_BITS-1:0] d, input logic stop, input int gap_at,
                      input int gap_len, input logic extra_found, input logic glitch,
                      input int abort_at, input logic exp_err, input int exp_lat,
                      input logic b2b);
    int k;
    int gaps;
    if (abort_at == 0) begin
      exp_t e;
      e.data   = d;
      e.err    = exp_err;
      e.at_cyc = cyc + 1 + exp_lat;
      sb.push_back(e);
    end
    en    = 1'b1;
    found = 1'b1;
    rx    = 1'b0;
    @(negedge clk);
    found = 1'b0;
    k     = 0;
    gaps  = gap_len;
    while (k < TOTAL) begin
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      if (abort_at != 0 && k == abort_at) begin
        #2;
        rst_n      = 1'b0;
        model_data = '0;
        #1;
        check("abort_outputs", {21'd0, data, valid, ferr, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        return;
      end
      if (gaps > 0 && k + 1 == gap_at) begin
        en    = 1'b0;
        found = 1'b0;
        gaps--;
      end else begin
        k++;
        en    = 1'b1;
        rx    = line_bit(d, stop, k, glitch);
        found = extra_found && (k == 20 || k == 100);
      end
      @(negedge clk);
    end
    found = 1'b0;
    rx    = 1'b1;
    check("busy_after_stop", {31'd0, busy}, 32'd0);
    if (!b2b) repeat (5) @(negedge clk);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap_at: 0,  gap_len: 0,  extra_found: 1'b0, glitch: 1'b0, exp_err: 1'b0, exp_lat: 144};
    vecs[1] = '{data: 8'h3C, stop: 1'b1, gap_at: 0,  gap_len: 0,  extra_found: 1'b0, glitch: 1'b0, exp_err: 1'b0, exp_lat: 144};
    vecs[2] = '{data: 8'h7E, stop: 1'b0, gap_at: 0,  gap_len: 0,  extra_found: 1'b0, glitch: 1'b0, exp_err: 1'b1, exp_lat: 144};
    vecs[3] = '{data: 8'h81, stop: 1'b1, gap_at: 58, gap_len: 10, extra_found: 1'b0, glitch: 1'b0, exp_err: 1'b0, exp_lat: 154};
    vecs[4] = '{data: 8'h55, stop: 1'b1, gap_at: 0,  gap_len: 0,  extra_found: 1'b1, glitch: 1'b1, exp_err: 1'b0, exp_lat: 144};

    rst_n = 1'b0;
    en    = 1'b0;
    rx    = 1'b1;
    found = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {21'd0, data, valid, ferr, busy}, 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2) @(negedge clk);

    // i_found with i_en low must not start a frame.
    en    = 1'b0;
    found = 1'b1;
    @(negedge clk);
    found = 1'b0;
    en    = 1'b1;
    check("found_ignored_en0", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].data, vecs[i].stop, vecs[i].gap_at, vecs[i].gap_len,
           vecs[i].extra_found, vecs[i].glitch, 0, vecs[i].exp_err, vecs[i].exp_lat, 1'b0);
    end

    // Reset mid-frame, then a clean frame.
    send(8'h99, 1'b1, 0, 0, 1'b0, 1'b0, 70, 1'b0, 144, 1'b0);
    check("after_reset_busy", {31'd0, busy}, 32'd0);
    send(8'hC3, 1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 144, 1'b0);

    // Back-to-back frames with no idle gap.
    send(8'h00, 1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 144, 1'b1);
    send(8'hFF, 1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 144, 1'b0);

    repeat (20) @(negedge clk);
    check("pending_expectations", sb.size(), 32'd0);
    check("final_data", {24'd0, data}, 32'h000000FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
